hello_counter: RTL and testbench

//   Free-running 11-bit up-counter used as the smallest formal/simulation

---
 rtl/hello_pkg.sv | 6 +
 rtl/hello_props.sv | 37 +++
 rtl/hello_counter.sv | 47 ++++
 tb/tb_hello_counter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/hello_pkg.sv
// Shared widths and types for the hello_counter smoke-test target.
package hello_pkg;
    localparam int              CNT_W   = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/hello_props.sv
// Embedded properties for hello_counter; written to hold from an arbitrary
// starting state so that induction can close without reset history.
module hello_props
    import hello_pkg::*;
#(
    parameter int               WIDTH   = CNT_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic             clk,
    input logic             rst,
    input logic [WIDTH-1:0] cnt,
    input logic             wrap_o
);

`ifdef FORMAL
    logic past_valid_q = 1'b0;

    always_ff @(posedge clk) past_valid_q <= 1'b1;

    always_ff @(posedge clk) begin
        if (past_valid_q) begin
            if ($past(rst)) begin
                assert (cnt == RST_VAL);
                assert (!wrap_o);
            end else begin
                assert (cnt == WIDTH'($past(cnt) + 1'b1));
            end
            assert (wrap_o == (($past(cnt) == {WIDTH{1'b1}}) && !$past(rst)));
        end
        cover (wrap_o);
    end
`else
    logic unused_props;
    assign unused_props = ^{clk, rst, cnt, wrap_o};
`endif

endmodule

// File: rtl/hello_counter.sv
// Free-running WIDTH-bit up-counter with a registered one-cycle wrap pulse.
module hello_counter
    import hello_pkg::*;
#(
    parameter int               WIDTH   = CNT_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o
);

    // cnt keeps its bare name so benches and formal can reach it hierarchically
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt + 1'b1;
        wrap_d = (cnt == {WIDTH{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= RST_VAL;
            wrap_q <= 1'b0;
        end else begin
            cnt    <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o  = cnt;
    assign wrap_o = wrap_q;

    hello_props #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_props (
        .clk    (clk),
        .rst    (rst),
        .cnt    (cnt),
        .wrap_o (wrap_q)
    );

endmodule

// File: tb/tb_hello_counter.sv
// Self-checking bench for hello_counter: directed vectors, forced-state corners
// and a randomized run against an arithmetic reference model.
module tb_hello_counter;
    import hello_pkg::*;

    localparam int MODV = 2 ** CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cnt_t cnt_o;
    logic wrap_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hello_counter dut (
        .clk    (clk),
        .rst    (rst),
        .cnt_o  (cnt_o),
        .wrap_o (wrap_o)
    );

    typedef struct {
        logic rst;
        int   cnt;
        logic wrap;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   wraps;
        int   m_cnt;
        logic m_wrap;
        logic r;

        // forced value is overridden by the reset edge
        rst = 1'b1;
        force dut.cnt = 11'h7FE;
        #1;
        release dut.cnt;
        step(1'b1);
        check("t2_rst_cnt", 32'(cnt_o), 0);
        check("t2_rst_wrap", 32'(wrap_o), 0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            check("t2_cnt", 32'(cnt_o), i);
            check("t2_wrap", 32'(wrap_o), 0);
        end

        tbl[0] = '{1'b1, 0, 1'b0};
        tbl[1] = '{1'b1, 0, 1'b0};
        tbl[2] = '{1'b0, 1, 1'b0};
        tbl[3] = '{1'b0, 2, 1'b0};
        tbl[4] = '{1'b0, 3, 1'b0};
        tbl[5] = '{1'b0, 4, 1'b0};
        tbl[6] = '{1'b0, 5, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rst);
            check("t1_cnt", 32'(cnt_o), 32'(tbl[i].cnt));
            check("t1_wrap", 32'(wrap_o), 32'(tbl[i].wrap));
        end

        // arbitrary start state without reset, stepped in through 2045 -> 2046
        rst = 1'b0;
        force dut.cnt = 11'h7FD;
        @(posedge clk);
        #1;
        force dut.cnt = 11'h7FE;
        #1;
        check("t3_cnt_2046", 32'(cnt_o), 2046);
        release dut.cnt;
        step(1'b0);
        check("t3_cnt_2047", 32'(cnt_o), 2047);
        check("t3_wrap_2047", 32'(wrap_o), 0);
        step(1'b0);
        check("t3_cnt_0", 32'(cnt_o), 0);
        check("t3_wrap_0", 32'(wrap_o), 1);
        step(1'b0);
        check("t3_cnt_1", 32'(cnt_o), 1);
        check("t3_wrap_1", 32'(wrap_o), 0);

        step(1'b1);
        repeat (MODV - 1) step(1'b0);
        check("t4_cnt_max", 32'(cnt_o), MODV - 1);
        check("t4_wrap_max", 32'(wrap_o), 0);
        step(1'b1);
        check("t4_rst_cnt", 32'(cnt_o), 0);
        check("t4_rst_wrap", 32'(wrap_o), 0);
        step(1'b0);
        check("t4_after_cnt", 32'(cnt_o), 1);
        check("t4_after_wrap", 32'(wrap_o), 0);

        step(1'b1);
        wraps = 0;
        for (int i = 0; i < MODV; i++) begin
            step(1'b0);
            if (wrap_o === 1'b1) begin
                wraps++;
                check("t5_cnt_at_wrap", 32'(cnt_o), 0);
            end
        end
        check("t5_wrap_count", 32'(wraps), 1);
        check("t5_final_cnt", 32'(cnt_o), 0);

        step(1'b1);
        m_cnt  = 0;
        m_wrap = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            r      = ($urandom_range(0, 1023) == 0);
            m_wrap = !r && (m_cnt == MODV - 1);
            m_cnt  = r ? 0 : (m_cnt + 1) % MODV;
            step(r);
            check("rnd_cnt", 32'(cnt_o), 32'(m_cnt));
            check("rnd_wrap", 32'(wrap_o), 32'(m_wrap));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
